hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_stall_counter.sv | 35 +++
 rtl/hazard_controller.sv | 125 ++++++++++++
 tb/tb_hazard_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//   REG_ADDR_W   : register-address width
//   WAIT_CNT_W   : width of the memory-wait counter
//   WAIT_LIMIT   : wait count at which the sticky timeout flag is raised
//   STALL_CNT_W  : width of the stall performance counter
//   hz_state_e   : controller state encoding
//   load_use_hazard() : load-use dependency detect between EX and ID
package hazard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int WAIT_CNT_W  = 8;
  localparam int STALL_CNT_W = 16;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hz_state_e;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] id_rs,
    input logic [REG_ADDR_W-1:0] id_rt
  );
    return mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// hazard_stall_counter -- saturating up-counter of stalled clocks.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count this clock
//   count : current count, holds at all-ones
module hazard_stall_counter
  import hazard_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller -- pipeline stall / flush / freeze control.
// Handles load-use bubbles, taken-branch IF/ID flush and full-pipeline
// freeze while data memory is busy, with a sticky memory-wait timeout.
// Optional feature: define HAZARD_STALL_CNT_EN to count stalled clocks on
// stall_cycles; otherwise stall_cycles is tied to zero.
// Ports:
//   clk, rst_n            : clock (rising) / asynchronous active-low reset
//   ID_EX_mem_read, ID_EX_rt : load in EX and its destination register
//   IF_ID_rs, IF_ID_rt    : source registers of the instruction in ID
//   branch_taken          : branch in ID resolved taken
//   mem_busy              : data memory cannot complete this cycle
//   pc_write, IF_ID_write : PC / IF-ID load enables
//   IF_ID_flush           : clear IF/ID to NOP
//   pipe_en               : ID/EX, EX/MEM, MEM/WB load enable
//   ctrl_sel              : 1 pass ID controls, 0 insert bubble
//   mem_timeout           : sticky memory-wait timeout flag
//   stall_cycles          : stalled-clock performance count
module hazard_controller
  import hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EX_mem_read,
  input  logic [REG_ADDR_W-1:0]  ID_EX_rt,
  input  logic [REG_ADDR_W-1:0]  IF_ID_rs,
  input  logic [REG_ADDR_W-1:0]  IF_ID_rt,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   IF_ID_flush,
  output logic                   pipe_en,
  output logic                   ctrl_sel,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  hazard;

  assign hazard = load_use_hazard(ID_EX_mem_read, ID_EX_rt, IF_ID_rs, IF_ID_rt);

  // Mealy outputs: reset, then memory freeze, then per-state behaviour.
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    pipe_en     = 1'b1;
    ctrl_sel    = 1'b1;
    IF_ID_flush = 1'b0;
    if (!rst_n) begin
      // Outputs track reset combinationally so the pipeline sees a bubble
      // without waiting for a clock.
      ctrl_sel = 1'b0;
      state_d  = ST_RUN;
    end else if (mem_busy) begin
      // Freeze everything; no bubble so the stalled instruction is preserved.
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_en     = 1'b0;
      state_d     = ST_MEM_WAIT;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            // Hazard beats a coincident branch; the branch is re-seen next cycle.
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ctrl_sel    = 1'b0;
            state_d     = ST_LOAD_STALL;
          end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
          end
        end
        ST_LOAD_STALL: begin
          // Hazard ignored here: at most one consecutive bubble.
          IF_ID_flush = branch_taken;
          state_d     = ST_RUN;
        end
        ST_MEM_WAIT: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ST_MEM_WAIT) && mem_busy) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  hazard_stall_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .count (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ID_EX_mem_read;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        pipe_en;
  logic        ctrl_sel;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  hazard_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rt       (ID_EX_rt),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .pipe_en        (pipe_en),
    .ctrl_sel       (ctrl_sel),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector order: {pc_write, IF_ID_write, IF_ID_flush, pipe_en, ctrl_sel}
  localparam logic [4:0] O_PASS   = 5'b11011;
  localparam logic [4:0] O_FLUSH  = 5'b11111;
  localparam logic [4:0] O_BUBBLE = 5'b00010;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b11010;

  typedef struct {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       busy;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[17];
  logic [4:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_stalls = 0;

  function automatic vec_t mk(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                              input logic [4:0] rt, input logic br, input logic busy,
                              input logic [4:0] exp);
    vec_t v;
    v.mr = mr; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {pc_write, IF_ID_write, IF_ID_flush, pipe_en, ctrl_sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic busy);
    ID_EX_mem_read = mr; ID_EX_rt = ex_rt; IF_ID_rs = rs; IF_ID_rt = rt;
    branch_taken = br; mem_busy = busy;
  endtask

  // Called just after a rising edge: drive, sample mid-cycle, advance one edge.
  task automatic step(input vec_t v, input string nm);
    logic [4:0] want;
    drive(v.mr, v.ex_rt, v.rs, v.rt, v.br, v.busy);
    sb.push_back(v.exp);
    if (v.exp[4] == 1'b0) exp_stalls++;
    @(negedge clk);
    want = sb.pop_front();
    chk(nm, {27'd0, outs()}, {27'd0, want});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            mr  ex_rt  rs     rt     br    busy  expected
    vecs[0]  = mk(0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, O_PASS);   // idle
    vecs[1]  = mk(1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, O_BUBBLE); // load r5, use rs=5
    vecs[2]  = mk(1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, O_PASS);   // stall cycle ignores hazard
    vecs[3]  = mk(0, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, O_PASS);   // normal again
    vecs[4]  = mk(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_PASS);   // load r0 never stalls
    vecs[5]  = mk(1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, O_BUBBLE); // rt match + branch: hazard wins
    vecs[6]  = mk(0, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, O_FLUSH);  // branch re-seen in stall state
    vecs[7]  = mk(0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, O_FLUSH);  // plain branch in RUN
    vecs[8]  = mk(1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, O_PASS);   // load with no dependency
    vecs[9]  = mk(1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, O_FREEZE); // busy during load-use
    vecs[10] = mk(1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, O_FREEZE);
    vecs[11] = mk(1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, O_FREEZE);
    vecs[12] = mk(1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, O_PASS);   // release: hazard not evaluated
    vecs[13] = mk(1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, O_BUBBLE); // persisting hazard bubbles once
    vecs[14] = mk(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_FREEZE); // busy from stall state
    vecs[15] = mk(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, O_PASS);   // release with branch: no flush
    vecs[16] = mk(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, O_FLUSH);  // branch back in RUN

    // Reset state: outputs forced even with busy/branch asserted.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    #12;
    chk("reset_outs", {27'd0, outs()}, {27'd0, O_RESET});
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    chk("table_stall_cycles", {16'd0, stall_cycles}, CNT_EN ? exp_stalls : 0);

    // Asynchronous reset mid-cycle clears counters without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_stalls = 0;
    @(posedge clk);
    #1;

    // Long memory wait: timeout after 256 busy cycles, sticky after release.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 1)   chk("mw_freeze", {27'd0, outs()}, {27'd0, O_FREEZE});
      if (i == 255) chk("timeout_before", {31'd0, mem_timeout}, 32'd0);
      if (i == 256) chk("timeout_at_256", {31'd0, mem_timeout}, 32'd1);
    end
    chk("mw_stall_cycles", {16'd0, stall_cycles}, CNT_EN ? 300 : 0);
    mem_busy = 1'b0;
    #1;
    chk("mw_release_outs", {27'd0, outs()}, {27'd0, O_PASS});
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("post_wait_outs", {27'd0, outs()}, {27'd0, O_PASS});

    // Reset asserted while in LOAD_STALL abandons the stall.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ls_outs", {27'd0, outs()}, {27'd0, O_PASS});
    #2;
    rst_n = 1'b0;
    #1;
    chk("ls_rst_outs", {27'd0, outs()}, {27'd0, O_RESET});
    chk("ls_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("ls_rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Back in RUN: the still-present hazard produces a fresh bubble.
    chk("ls_rst_run_bubble", {27'd0, outs()}, {27'd0, O_BUBBLE});
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("final_outs", {27'd0, outs()}, {27'd0, O_PASS});
    chk("final_stall_cycles", {16'd0, stall_cycles}, CNT_EN ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
